register_file_ss: RTL and testbench
===================================

Name: register_file_ss

Overview:
- Parametrised successor of the CPU register file.
- Generalises width, depth and write-port count, and adds per-byte-lane write enables with fixed port priority.
- Adds a savestate engine that serially dumps or loads every register over valid/ready streams.
- Sits between the CPU core datapath and the savestate controller.

Parameters:
NUM_REGISTERS, 8, number of registers (≥2)
DATA_WIDTH, 16, register width in bits; multiple of LANE_WIDTH
LANE_WIDTH, 8, bits per byte-lane enable
NUM_WRITE_PORTS, 2, write ports; port 0 highest priority
(derived) IDW = $clog2(NUM_REGISTERS), NUM_LANES = DATA_WIDTH/LANE_WIDTH

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
we  in  NUM_WRITE_PORTS  per-port write enable
write_id  in  NUM_WRITE_PORTS×IDW  per-port target register
write_lanes  in  NUM_WRITE_PORTS×NUM_LANES  per-port lane enables
write_data  in  NUM_WRITE_PORTS×DATA_WIDTH  per-port data
registers  out  NUM_REGISTERS×DATA_WIDTH  flop contents, direct view
ss_dump_start  in  1  pulse: begin dump
ss_load_start  in  1  pulse: begin load
ss_dout  out  DATA_WIDTH  dump word
ss_dout_valid  out  1  dump word valid
ss_dout_ready  in  1  consumer accepts
ss_din  in  DATA_WIDTH  load word
ss_din_valid  in  1  load word valid
ss_din_ready  out  1  engine accepts
ss_busy  out  1  engine not IDLE
ss_done  out  1  one-cycle pulse at end of dump/load

Behaviour:
- Reset: clk and reset_n only; reset is asynchronous and active-low, no other reset source. All registers, the index counter, ss_dout, ss_dout_valid, ss_din_ready, ss_busy and ss_done go to 0. State goes to IDLE.
- Normal writes (state IDLE only):
  - All updates take effect at the clock edge.
  - For each register and lane, the lowest-index port with we, matching write_id and lane enable set writes that lane. Lanes not written hold their value.
  - Two ports may write different lanes of one register in the same cycle; the merge is independent per lane.
  - write_id ≥ NUM_REGISTERS: write ignored.
- No read ports: registers is the flop output, so a write is visible the cycle after its edge (1-cycle latency, no bypass).
- FSM states: IDLE, DUMP, LOAD, DONE.
- IDLE:
  - ss_dump_start → DUMP, idx=0.
  - Else ss_load_start → LOAD, idx=0.
  - Both asserted in the same cycle: dump wins.
- DUMP:
  - ss_dout = registers[idx] (registered) and ss_dout_valid=1.
  - On valid&&ready: idx+1. At idx=NUM_REGISTERS-1 → DONE.
  - ss_dout holds stable while valid && !ready.
- LOAD:
  - ss_din_ready=1.
  - On valid&&ready: registers[idx] <= ss_din (full width), idx+1. At the last index → DONE.
- DONE: ss_done=1 for one cycle → IDLE.
- While busy (DUMP/LOAD/DONE):
  - all normal writes are dropped, not queued;
  - start pulses are ignored;
  - ss_busy=1.
- Out-of-state outputs: ss_dout_valid=0 outside DUMP; ss_din_ready=0 outside LOAD.
- reset_n low mid-dump or mid-load: abort immediately and take reset values. No ss_done. Partial load contents are cleared by reset.
- Stream order: ascending register index, one word per register, no header.

Decomposition:
- Package register_file_ss_pkg holds:
  - ss_state_t enum {IDLE, DUMP, LOAD, DONE};
  - a function computing the lane-merged write value for one register from the packed port buses.
- Sub-module register_file_ss_lane_merge (priority resolver for one register): natural, instantiated NUM_REGISTERS times.
- FSM and counter stay in the top.

Test Plan:
- Reset, then port0 writes reg 3 = 16'hBEEF, lanes 2'b11 → registers[3]=16'hBEEF next cycle; all other registers 0.
- Same cycle: port0 writes reg 2 = 16'h1234 lanes 2'b01; port1 writes reg 2 = 16'hABCD lanes 2'b11 → registers[2]=16'hAB34.
- Same cycle: both ports write reg 5, lanes 2'b11, data 16'h1111 (port0) and 16'h2222 (port1) → registers[5]=16'h1111.
- Preload regs to i×16'h0101, pulse ss_dump_start, hold ss_dout_ready low 3 cycles then high → 8 words 16'h0000..16'h0707 in order; ss_dout stable while stalled; ss_done one pulse; a we during dump has no effect.
- Pulse ss_load_start, stream 16'hF000+i with valid gaps → registers[i]=16'hF000+i; ss_din_ready low after done; ss_busy low the cycle after ss_done.
- Start a load, accept 3 words, assert reset_n low asynchronously between edges → all registers 0 and state IDLE immediately; ss_done never pulses.

Source files
------------

// File: rtl/register_file_ss_pkg.sv
// rtl/register_file_ss_pkg.sv - shared types and lane-merge helper for register_file_ss
package register_file_ss_pkg;

    typedef enum logic [1:0] {IDLE, DUMP, LOAD, DONE} ss_state_t;

    // Bounds of the helper's padded buses. Callers zero-extend their
    // packed buses into these, which keeps per-port strides intact.
    localparam int MAX_PORTS = 8;
    localparam int MAX_LANES = 16;
    localparam int MAX_DW    = 128;

    // Lane-merged next value of one register. Ports are scanned from highest to lowest,
    // so the lowest-index port hitting a lane has the final say.
    function automatic logic [MAX_DW-1:0] merge_lanes(
        input logic [MAX_DW-1:0]              cur,
        input logic [MAX_PORTS-1:0]           hit,
        input logic [MAX_PORTS*MAX_LANES-1:0] lanes,
        input logic [MAX_PORTS*MAX_DW-1:0]    data,
        input int                             nports,
        input int                             nlanes,
        input int                             lane_w
    );
        logic [MAX_DW-1:0] res;
        res = cur;
        for (int i = 0; i < MAX_DW; i++) begin
            if (i < nlanes * lane_w) begin
                for (int p = MAX_PORTS - 1; p >= 0; p--) begin
                    if (p < nports && hit[p] && lanes[p * nlanes + i / lane_w]) begin
                        res[i] = data[p * nlanes * lane_w + i];
                    end
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/register_file_ss_lane_merge.sv
// rtl/register_file_ss_lane_merge.sv - write-port priority resolver for one register
module register_file_ss_lane_merge
    import register_file_ss_pkg::*;
#(
    parameter int NUM_WRITE_PORTS = 2,
    parameter int DATA_WIDTH      = 16,
    parameter int LANE_WIDTH      = 8,
    parameter int IDW             = 3,
    parameter int REG_INDEX       = 0,
    localparam int NUM_LANES      = DATA_WIDTH / LANE_WIDTH
) (
    input  logic [DATA_WIDTH-1:0]                 cur,
    input  logic [NUM_WRITE_PORTS-1:0]            we,
    input  logic [NUM_WRITE_PORTS*IDW-1:0]        write_id,
    input  logic [NUM_WRITE_PORTS*NUM_LANES-1:0]  write_lanes,
    input  logic [NUM_WRITE_PORTS*DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0]                 next_value
);

    logic [MAX_PORTS-1:0]           hit_w;
    logic [MAX_PORTS*MAX_LANES-1:0] lanes_w;
    logic [MAX_PORTS*MAX_DW-1:0]    data_w;
    logic [MAX_DW-1:0]              cur_w;

    always_comb begin
        hit_w   = '0;
        lanes_w = '0;
        data_w  = '0;
        cur_w   = '0;
        for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
            hit_w[p] = we[p] && (write_id[p*IDW +: IDW] == IDW'(REG_INDEX));
        end
        lanes_w[NUM_WRITE_PORTS*NUM_LANES-1:0]  = write_lanes;
        data_w[NUM_WRITE_PORTS*DATA_WIDTH-1:0]  = write_data;
        cur_w[DATA_WIDTH-1:0]                   = cur;
        next_value = DATA_WIDTH'(merge_lanes(cur_w, hit_w, lanes_w, data_w,
                                             NUM_WRITE_PORTS, NUM_LANES, LANE_WIDTH));
    end

endmodule

// File: rtl/register_file_ss.sv
// rtl/register_file_ss.sv - multi-port byte-lane register file with serial savestate engine
module register_file_ss
    import register_file_ss_pkg::*;
#(
    parameter int NUM_REGISTERS   = 8,
    parameter int DATA_WIDTH      = 16,
    parameter int LANE_WIDTH      = 8,
    parameter int NUM_WRITE_PORTS = 2,
    localparam int IDW            = $clog2(NUM_REGISTERS),
    localparam int NUM_LANES      = DATA_WIDTH / LANE_WIDTH
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [NUM_WRITE_PORTS-1:0]            we,
    input  logic [NUM_WRITE_PORTS*IDW-1:0]        write_id,
    input  logic [NUM_WRITE_PORTS*NUM_LANES-1:0]  write_lanes,
    input  logic [NUM_WRITE_PORTS*DATA_WIDTH-1:0] write_data,
    output logic [NUM_REGISTERS*DATA_WIDTH-1:0]   registers,
    input  logic                                  ss_dump_start,
    input  logic                                  ss_load_start,
    output logic [DATA_WIDTH-1:0]                 ss_dout,
    output logic                                  ss_dout_valid,
    input  logic                                  ss_dout_ready,
    input  logic [DATA_WIDTH-1:0]                 ss_din,
    input  logic                                  ss_din_valid,
    output logic                                  ss_din_ready,
    output logic                                  ss_busy,
    output logic                                  ss_done
);

    localparam logic [IDW-1:0] LAST_IDX = IDW'(NUM_REGISTERS - 1);

    logic [NUM_REGISTERS-1:0][DATA_WIDTH-1:0] regs_q;
    logic [NUM_REGISTERS-1:0][DATA_WIDTH-1:0] merged;
    ss_state_t                                state;
    logic [IDW-1:0]                           idx;

    for (genvar r = 0; r < NUM_REGISTERS; r++) begin : g_merge
        register_file_ss_lane_merge #(
            .NUM_WRITE_PORTS(NUM_WRITE_PORTS),
            .DATA_WIDTH     (DATA_WIDTH),
            .LANE_WIDTH     (LANE_WIDTH),
            .IDW            (IDW),
            .REG_INDEX      (r)
        ) u_merge (
            .cur        (regs_q[r]),
            .we         (we),
            .write_id   (write_id),
            .write_lanes(write_lanes),
            .write_data (write_data),
            .next_value (merged[r])
        );
    end

    assign registers = regs_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regs_q        <= '0;
            state         <= IDLE;
            idx           <= '0;
            ss_dout       <= '0;
            ss_dout_valid <= 1'b0;
            ss_din_ready  <= 1'b0;
            ss_busy       <= 1'b0;
            ss_done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    regs_q <= merged;
                    idx    <= '0;
                    if (ss_dump_start) begin
                        state         <= DUMP;
                        ss_dout       <= regs_q[0];
                        ss_dout_valid <= 1'b1;
                        ss_busy       <= 1'b1;
                    end else if (ss_load_start) begin
                        state        <= LOAD;
                        ss_din_ready <= 1'b1;
                        ss_busy      <= 1'b1;
                    end
                end
                DUMP: begin
                    if (ss_dout_ready) begin
                        if (idx == LAST_IDX) begin
                            state         <= DONE;
                            ss_dout_valid <= 1'b0;
                            ss_done       <= 1'b1;
                        end else begin
                            idx     <= idx + 1'b1;
                            ss_dout <= regs_q[idx + 1'b1];
                        end
                    end
                end
                LOAD: begin
                    if (ss_din_valid) begin
                        regs_q[idx] <= ss_din;
                        if (idx == LAST_IDX) begin
                            state        <= DONE;
                            ss_din_ready <= 1'b0;
                            ss_done      <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    ss_done <= 1'b0;
                    ss_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_register_file_ss.sv
// tb/tb_register_file_ss.sv - scoreboard bench for register_file_ss
module tb_register_file_ss;

    localparam int NR = 8;
    localparam int DW = 16;
    localparam int NP = 2;
    localparam int IW = 3;
    localparam int NL = 2;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [NP-1:0]     we = '0;
    logic [NP*IW-1:0]  write_id = '0;
    logic [NP*NL-1:0]  write_lanes = '0;
    logic [NP*DW-1:0]  write_data = '0;
    logic [NR*DW-1:0]  registers;
    logic              ss_dump_start = 1'b0;
    logic              ss_load_start = 1'b0;
    logic [DW-1:0]     ss_dout;
    logic              ss_dout_valid;
    logic              ss_dout_ready = 1'b0;
    logic [DW-1:0]     ss_din = '0;
    logic              ss_din_valid = 1'b0;
    logic              ss_din_ready;
    logic              ss_busy;
    logic              ss_done;

    int n_tests = 0;
    int n_fail  = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    register_file_ss dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .we           (we),
        .write_id     (write_id),
        .write_lanes  (write_lanes),
        .write_data   (write_data),
        .registers    (registers),
        .ss_dump_start(ss_dump_start),
        .ss_load_start(ss_load_start),
        .ss_dout      (ss_dout),
        .ss_dout_valid(ss_dout_valid),
        .ss_dout_ready(ss_dout_ready),
        .ss_din       (ss_din),
        .ss_din_valid (ss_din_valid),
        .ss_din_ready (ss_din_ready),
        .ss_busy      (ss_busy),
        .ss_done      (ss_done)
    );

    function automatic logic [DW-1:0] reg_at(input int r);
        return registers[r*DW +: DW];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic en, input logic [IW-1:0] id,
                            input logic [NL-1:0] ln, input logic [DW-1:0] d);
        we[p]                  = en;
        write_id[p*IW +: IW]   = id;
        write_lanes[p*NL +: NL] = ln;
        write_data[p*DW +: DW] = d;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
        for (int r = 0; r < NR; r++) begin
            n_tests++;
            if (reg_at(r) !== 16'h0) begin
                n_fail++;
                $display("FAIL reset_reg%0d got %h exp 0000", r, reg_at(r));
            end
        end
        n_tests++;
        if ({ss_busy, ss_done, ss_dout_valid, ss_din_ready} !== 4'b0 || ss_dout !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_ctrl got busy%b done%b ov%b ir%b dout%h exp all 0",
                     ss_busy, ss_done, ss_dout_valid, ss_din_ready, ss_dout);
        end
    endtask

    task automatic test_single_write();
        set_port(0, 1'b1, 3'd3, 2'b11, 16'hBEEF);
        step();
        set_port(0, 1'b0, 3'd0, 2'b00, 16'h0);
        for (int r = 0; r < NR; r++) exp_q.push_back(r == 3 ? 16'hBEEF : 16'h0);
        for (int r = 0; r < NR; r++) begin
            logic [DW-1:0] e;
            e = exp_q.pop_front();
            n_tests++;
            if (reg_at(r) !== e) begin
                n_fail++;
                $display("FAIL single_write_reg%0d got %h exp %h", r, reg_at(r), e);
            end
        end
    endtask

    task automatic test_lane_merge();
        set_port(0, 1'b1, 3'd2, 2'b01, 16'h1234);
        set_port(1, 1'b1, 3'd2, 2'b11, 16'hABCD);
        exp_q.push_back(16'hAB34);
        step();
        set_port(0, 1'b0, 3'd0, 2'b00, 16'h0);
        set_port(1, 1'b0, 3'd0, 2'b00, 16'h0);
        begin
            logic [DW-1:0] e;
            e = exp_q.pop_front();
            n_tests++;
            if (reg_at(2) !== e) begin
                n_fail++;
                $display("FAIL lane_merge got %h exp %h", reg_at(2), e);
            end
        end
    endtask

    task automatic test_priority();
        set_port(0, 1'b1, 3'd5, 2'b11, 16'h1111);
        set_port(1, 1'b1, 3'd5, 2'b11, 16'h2222);
        exp_q.push_back(16'h1111);
        step();
        set_port(0, 1'b0, 3'd0, 2'b00, 16'h0);
        set_port(1, 1'b0, 3'd0, 2'b00, 16'h0);
        begin
            logic [DW-1:0] e;
            e = exp_q.pop_front();
            n_tests++;
            if (reg_at(5) !== e) begin
                n_fail++;
                $display("FAIL port_priority got %h exp %h", reg_at(5), e);
            end
        end
    endtask

    task automatic test_dump();
        int done_cnt;
        int words;
        logic [DW-1:0] held;
        for (int r = 0; r < NR; r++) begin
            set_port(r % 2, 1'b1, IW'(r), 2'b11, DW'(r * 16'h0101));
            step();
            set_port(r % 2, 1'b0, 3'd0, 2'b00, 16'h0);
            exp_q.push_back(DW'(r * 16'h0101));
        end
        ss_dump_start = 1'b1;
        step();
        ss_dump_start = 1'b0;
        set_port(0, 1'b1, 3'd1, 2'b11, 16'hFFFF);
        held = ss_dout;
        for (int c = 0; c < 3; c++) begin
            n_tests++;
            if (ss_dout_valid !== 1'b1 || ss_dout !== exp_q[0] || ss_dout !== held) begin
                n_fail++;
                $display("FAIL dump_stall c%0d got v%b %h exp v1 %h", c, ss_dout_valid, ss_dout, exp_q[0]);
            end
            step();
        end
        set_port(0, 1'b0, 3'd0, 2'b00, 16'h0);
        ss_dout_ready = 1'b1;
        done_cnt = 0;
        words = 0;
        for (int c = 0; c < 40 && done_cnt == 0; c++) begin
            if (ss_dout_valid && ss_dout_ready) begin
                logic [DW-1:0] e;
                e = exp_q.size() > 0 ? exp_q.pop_front() : 16'hxxxx;
                words++;
                n_tests++;
                if (ss_dout !== e) begin
                    n_fail++;
                    $display("FAIL dump_word%0d got %h exp %h", words - 1, ss_dout, e);
                end
            end
            step();
            if (ss_done) done_cnt++;
        end
        ss_dout_ready = 1'b0;
        step();
        if (ss_done) done_cnt++;
        n_tests++;
        if (words !== NR || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL dump_count got words %0d done %0d exp %0d and 1", words, done_cnt, NR);
        end
        n_tests++;
        if (reg_at(1) !== 16'h0101 || ss_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL dump_drop_write got reg1 %h busy %b exp 0101 0", reg_at(1), ss_busy);
        end
        exp_q.delete();
    endtask

    task automatic test_load();
        ss_load_start = 1'b1;
        step();
        ss_load_start = 1'b0;
        for (int i = 0; i < NR; i++) begin
            n_tests++;
            if (ss_din_ready !== 1'b1 || ss_done !== 1'b0) begin
                n_fail++;
                $display("FAIL load_ready%0d got ready %b done %b exp 1 0", i, ss_din_ready, ss_done);
            end
            ss_din = DW'(16'hF000 + i);
            ss_din_valid = 1'b1;
            exp_q.push_back(DW'(16'hF000 + i));
            step();
            ss_din_valid = 1'b0;
            if (i % 2 == 1 && i != NR - 1) step();
        end
        n_tests++;
        if (ss_done !== 1'b1 || ss_din_ready !== 1'b0 || ss_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL load_done got done %b ready %b busy %b exp 1 0 1", ss_done, ss_din_ready, ss_busy);
        end
        step();
        n_tests++;
        if (ss_busy !== 1'b0 || ss_done !== 1'b0) begin
            n_fail++;
            $display("FAIL load_idle got busy %b done %b exp 0 0", ss_busy, ss_done);
        end
        for (int r = 0; r < NR; r++) begin
            logic [DW-1:0] e;
            e = exp_q.pop_front();
            n_tests++;
            if (reg_at(r) !== e) begin
                n_fail++;
                $display("FAIL load_reg%0d got %h exp %h", r, reg_at(r), e);
            end
        end
    endtask

    task automatic test_both_starts();
        int done_cnt;
        ss_dump_start = 1'b1;
        ss_load_start = 1'b1;
        step();
        ss_dump_start = 1'b0;
        ss_load_start = 1'b0;
        n_tests++;
        if (ss_dout_valid !== 1'b1 || ss_din_ready !== 1'b0 || ss_dout !== 16'hF000) begin
            n_fail++;
            $display("FAIL dump_wins got ov %b ir %b dout %h exp 1 0 f000", ss_dout_valid, ss_din_ready, ss_dout);
        end
        ss_dout_ready = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 20 && done_cnt == 0; c++) begin
            step();
            if (ss_done) done_cnt++;
        end
        ss_dout_ready = 1'b0;
        step();
        n_tests++;
        if (done_cnt !== 1 || ss_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL dump_wins_end got done %0d busy %b exp 1 0", done_cnt, ss_busy);
        end
    endtask

    task automatic test_reset_abort();
        int done_seen;
        done_seen = 0;
        ss_load_start = 1'b1;
        step();
        ss_load_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ss_din = DW'(16'h5A00 + i);
            ss_din_valid = 1'b1;
            step();
        end
        #3;
        reset_n = 1'b0;
        #1;
        for (int r = 0; r < NR; r++) begin
            n_tests++;
            if (reg_at(r) !== 16'h0) begin
                n_fail++;
                $display("FAIL abort_reg%0d got %h exp 0000", r, reg_at(r));
            end
        end
        n_tests++;
        if (ss_busy !== 1'b0 || ss_din_ready !== 1'b0 || ss_done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_ctrl got busy %b ready %b done %b exp 0 0 0", ss_busy, ss_din_ready, ss_done);
        end
        for (int c = 0; c < 2; c++) begin
            step();
            if (ss_done) done_seen++;
        end
        reset_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            if (ss_done) done_seen++;
        end
        ss_din_valid = 1'b0;
        set_port(1, 1'b1, 3'd7, 2'b10, 16'h9900);
        step();
        set_port(1, 1'b0, 3'd0, 2'b00, 16'h0);
        n_tests++;
        if (done_seen !== 0 || reg_at(7) !== 16'h9900 || ss_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle got done %0d reg7 %h busy %b exp 0 9900 0", done_seen, reg_at(7), ss_busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_lane_merge();
        test_priority();
        test_dump();
        test_load();
        test_both_starts();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
